// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shares one external 16-entry x 12-bit sprite palette LUT among N_REQ sprite
//   pipelines. A round-robin arbiter picks one pending index per cycle and drives
//   it to the LUT. The returned colour is captured in a 1-entry output register,
//   tagged with the requester ID.
//
// Optional feature macro: PALETTE_TRANSPARENCY_EN
//   When defined, this adds out_transparent. It is registered with the colour and
//   is set when the accepted index is 4'h0, the colour-key entry.
//
// Ports
//   Clk, Reset         clock, asynchronous active-high reset
//   req_valid/ready    per-requester handshake (req_ready is the one-hot grant)
//   req_index          4-bit index of requester i at [4i+3:4i]
//   pal_index          index to the external combinational LUT
//   pal_red/green/blue LUT colour for pal_index
//   out_valid/ready    result handshake
//   out_id, out_rgb    registered result
module palette_lookup_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_index,
    output logic [N_REQ-1:0]   req_ready,
    output logic [3:0]         pal_index,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [3:0]         out_red,
    output logic [3:0]         out_green,
    output logic [3:0]         out_blue
`ifdef PALETTE_TRANSPARENCY_EN
    ,
    output logic               out_transparent
`endif
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] rr_next;
    logic [ID_W:0]   cand;
    logic            gnt_found;
    logic            can_accept;
    logic            accept;

    // Search upward from rr_ptr, wrapping mod N_REQ. cand is one bit wider so
    // that rr_ptr + k never overflows before the wrap is applied.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = rr_ptr;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    // The output register frees up this cycle if it is empty or being drained.
    // Reset gates the grant so that nothing looks accepted while it is held.
    assign can_accept = !out_valid || out_ready;
    assign accept     = can_accept && gnt_found && !Reset;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[gnt_id] = 1'b1;
    end

    // With no grant, gnt_id falls back to rr_ptr, so the LUT still sees a stable index.
    assign pal_index = req_index[{gnt_id, 2'b00} +: 4];
    assign rr_next   = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            rr_ptr    <= '0;
`ifdef PALETTE_TRANSPARENCY_EN
            out_transparent <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_id    <= gnt_id;
            out_red   <= pal_red;
            out_green <= pal_green;
            out_blue  <= pal_blue;
            rr_ptr    <= rr_next;
`ifdef PALETTE_TRANSPARENCY_EN
            out_transparent <= (pal_index == 4'h0);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
module tb_palette_lookup_arbiter;
    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N-1:0] req_valid;
    logic [4*N-1:0] req_index;
    logic [N-1:0] req_ready;
    logic [3:0]   pal_index, pal_red, pal_green, pal_blue;
    logic         out_valid, out_ready;
    logic [1:0]   out_id;
    logic [3:0]   out_red, out_green, out_blue;
`ifdef PALETTE_TRANSPARENCY_EN
    logic         out_transparent;
`endif

    always #5 Clk = ~Clk;

    // Reference LUT contents: index 5 maps to A, C, D.
    function automatic logic [3:0] lr(input logic [3:0] i); return i ^ 4'hF; endfunction
    function automatic logic [3:0] lg(input logic [3:0] i); return i + 4'h7; endfunction
    function automatic logic [3:0] lb(input logic [3:0] i); return i + 4'h8; endfunction

    assign pal_red   = lr(pal_index);
    assign pal_green = lg(pal_index);
    assign pal_blue  = lb(pal_index);

    palette_lookup_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
`ifdef PALETTE_TRANSPARENCY_EN
        , .out_transparent(out_transparent)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    typedef struct {
        logic [1:0] id;
        logic [3:0] r, g, b;
        logic       t;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_rr = '0;
    logic       m_ov = 1'b0;

    // Reference model and scoreboard. Inputs change at posedge+1, so the values
    // sampled here are the ones the next posedge will act on.
    always @(negedge Clk) begin
        logic         can, found;
        logic [1:0]   gid;
        logic [N-1:0] exp_rdy;
        logic [3:0]   idx;
        exp_t         e;
        if (Reset) begin
            sb.delete();
            m_rr = '0;
            m_ov = 1'b0;
            chk("rst_ready", 32'(req_ready), 32'h0);
        end else begin
            can   = !m_ov || out_ready;
            found = 1'b0;
            gid   = '0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (int'(m_rr) + k) % N;
                if (!found && req_valid[c]) begin found = 1'b1; gid = 2'(c); end
            end
            exp_rdy = '0;
            if (can && found) exp_rdy[gid] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'h1);
                else begin
                    chk("out_id",    32'(out_id),    32'(sb[0].id));
                    chk("out_red",   32'(out_red),   32'(sb[0].r));
                    chk("out_green", 32'(out_green), 32'(sb[0].g));
                    chk("out_blue",  32'(out_blue),  32'(sb[0].b));
`ifdef PALETTE_TRANSPARENCY_EN
                    chk("out_transparent", 32'(out_transparent), 32'(sb[0].t));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (can && found) begin
                idx = req_index[4*gid +: 4];
                chk("pal_index", 32'(pal_index), 32'(idx));
                e.id = gid; e.r = lr(idx); e.g = lg(idx); e.b = lb(idx); e.t = (idx == 4'h0);
                sb.push_back(e);
                m_rr = gid + 2'd1;
            end
            m_ov = (can && found) || (m_ov && !out_ready);
        end
    end

    task automatic step(); @(posedge Clk); #1; endtask

    initial begin
        int acc;
        logic got;
        Reset = 1'b1; req_valid = '0; req_index = 16'h3210; out_ready = 1'b1;
        #2;
        req_valid = 4'hF;
        #1;
        chk("rst_ready_comb", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        step(); step();
        Reset = 1'b0;

        // Round-robin with all requesters valid.
        req_index = 16'h7A35;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            chk("rr_order", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            step();
        end

        // Reset mid-stream: the outputs clear without a clock edge.
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        Reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_rgb", 32'({out_id, out_red, out_green, out_blue}), 32'h0);
        step();
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_grant0", 32'(req_ready), 32'h1);
        step();

        // Single request from requester 2 with index 5.
        req_valid = '0;
        step(); step();
        req_index = 16'h0500;
        req_valid = 4'b0100;
        @(negedge Clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge Clk);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_id", 32'(out_id), 32'h2);
        chk("single_rgb", 32'({out_red, out_green, out_blue}), 32'h0ACD);
        step();

        // Backpressure: the first accept fills the register, then three stalled cycles.
        req_index = 16'h9C41;
        req_valid = 4'hF;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        @(negedge Clk);
        chk("bp_release", 32'(req_ready), 32'h1);
        step();

        // Fairness: requester 3 joins while requester 0 is always valid.
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        req_valid = 4'b1001;
        acc = 0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge Clk);
            if (req_ready != '0) acc++;
            if (req_ready[3]) got = 1'b1;
            step();
        end
        chk("fair_win", 32'(got && acc <= 4), 32'h1);

        // Colour-key index 0, followed by an ordinary index.
        req_valid = '0;
        step();
        req_index = 16'h0000;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
`ifdef PALETTE_TRANSPARENCY_EN
        @(negedge Clk);
        chk("transp_idx0", 32'(out_transparent), 32'h1);
`endif
        step();
        req_index = 16'h0003;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
`ifdef PALETTE_TRANSPARENCY_EN
        @(negedge Clk);
        chk("transp_idx3", 32'(out_transparent), 32'h0);
`endif
        step();

        // Random traffic: withdrawals, stalls, and index changes while idle.
        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] nv;
            nv = 4'($urandom);
            for (int j = 0; j < N; j++)
                if (!req_valid[j] && !nv[j]) req_index[4*j +: 4] = 4'($urandom);
            req_valid = nv;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        step(); step();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
